// File: rtl/de1_logic_sniffer.sv
// de1_logic_sniffer: SUMP-compatible 32-channel logic analyzer.
// UART command link, triggered capture into on-chip RAM, serial readout.
module de1_logic_sniffer #(
  parameter int FREQ  = 50_000_000,
  parameter int BAUD  = 921_600,
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        extClockIn,
  output logic        extClockOut,
  input  logic        extTriggerIn,
  output logic        extTriggerOut,
  input  logic [31:0] extData,
  output logic        dataReady,
  output logic        armLEDnn,
  output logic        triggerLEDnn,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int BIT  = FREQ / BAUD;
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = AW + 1;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    IDLE, ARMED, DELAY, READ
  } state_t;

  logic unused_ok;
  assign unused_ok = extClockIn;

  logic            rx_s1, rx_s2, rx_prev;
  rx_state_t       rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_valid;
  logic [7:0]      rx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_s2) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            // a low stop bit means a framing error: drop the byte
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [7:0]    fifo [8];
  logic [2:0]    wr_ptr, rd_ptr;
  logic [3:0]    fifo_cnt;
  logic          tx_busy;
  logic [8:0]    tx_shift;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic          push, pop, flush, full;
  logic [7:0]    push_data;

  assign full = fifo_cnt[3];
  assign pop  = (fifo_cnt != 4'd0) &&
                (!tx_busy ||
                 (tx_cnt == CW'(BIT - 1) && tx_bit == 4'd9));
  assign dataReady = tx_busy || (fifo_cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      uart_tx  <= 1'b1;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_bit   <= '0;
      tx_cnt   <= '0;
      uart_tx  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + {3'b0, push} - {3'b0, pop};
      // reloading at the end of the stop bit keeps frames gapless
      if (pop) begin
        tx_busy  <= 1'b1;
        tx_shift <= {1'b1, fifo[rd_ptr]};
        tx_bit   <= '0;
        tx_cnt   <= '0;
        uart_tx  <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt == CW'(BIT - 1)) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bit   <= tx_bit + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  state_t        state;
  logic          tg_s1, tg_s2;
  logic [23:0]   divider, div_cnt;
  logic [NW-1:0] read_count, delay_count;
  logic [NW-1:0] d_cnt, r_cnt;
  logic [1:0]    gi;
  logic [3:0]    grp_dis;
  logic          test_mode, trig_en;
  logic [31:0]   trig_mask, trig_val;
  logic [7:0]    tc;
  logic [AW-1:0] wp;
  logic [DEPTH-1:0] valid;
  logic          long_mode;
  logic [1:0]    lb_cnt;
  logic [7:0]    opcode;
  logic [23:0]   lval;
  logic          resp_on, resp_meta;
  logic [2:0]    resp_idx;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   sample, lv, rword;
  logic [AW-1:0] raddr;
  logic          strobe, hit, mem_we, busy_rd;
  logic          is_short, is_long_done, is_arm;
  logic          grp_on, rd_push, rd_step;
  logic          resp_push, resp_last;

  function automatic logic [NW-1:0] clamp(input logic [15:0] v);
    logic [18:0] n;
    n = {1'b0, v, 2'b00} + 19'd4;
    if (n >= 19'(DEPTH)) return NW'(DEPTH);
    return n[NW-1:0];
  endfunction

  function automatic logic [7:0] resp_byte(
    input logic meta, input logic [2:0] i
  );
    case ({meta, i})
      4'b0_000: return 8'h31;
      4'b0_001: return 8'h41;
      4'b0_010: return 8'h4C;
      4'b0_011: return 8'h53;
      4'b1_000: return 8'h01;
      4'b1_001: return 8'h44;
      4'b1_010: return 8'h45;
      4'b1_011: return 8'h31;
      default:  return 8'h00;
    endcase
  endfunction

  assign sample = test_mode ?
    {2'b11, tc[5:0], 2'b10, tc[5:0], 2'b01, tc[5:0], tc} :
    extData;
  assign strobe  = (div_cnt >= divider);
  assign hit     = !trig_en || (((sample ^ trig_val) & trig_mask) == '0);
  assign mem_we  = strobe && (state == ARMED || state == DELAY);
  assign busy_rd = (state == READ);

  assign lv           = {rx_data, lval};
  assign is_short     = rx_valid && !long_mode && !rx_data[7];
  assign is_long_done = rx_valid && long_mode && (lb_cnt == 2'd3);
  assign flush        = is_short && (rx_data == 8'h00);
  assign is_arm       = is_short && !busy_rd && (rx_data == 8'h01);

  // newest sample sits just behind the write pointer
  assign raddr   = wp - AW'(1) - r_cnt[AW-1:0];
  assign rword   = valid[raddr] ? mem[raddr] : '0;
  assign grp_on  = !grp_dis[gi];
  assign rd_push = busy_rd && grp_on && !full;
  assign rd_step = busy_rd && (!grp_on || !full);

  assign resp_last = resp_meta ? (resp_idx == 3'd5) : (resp_idx == 3'd3);
  assign resp_push = resp_on && !busy_rd && !full;
  assign push      = rd_push || resp_push;
  assign push_data = rd_push ? rword[{gi, 3'b000} +: 8] :
                     resp_byte(resp_meta, resp_idx);

  always_ff @(posedge clk) begin
    if (mem_we) mem[wp] <= sample;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tg_s1         <= 1'b0;
      tg_s2         <= 1'b0;
      divider       <= '0;
      div_cnt       <= '0;
      read_count    <= '0;
      delay_count   <= '0;
      d_cnt         <= '0;
      r_cnt         <= '0;
      gi            <= '0;
      grp_dis       <= '0;
      test_mode     <= 1'b0;
      trig_en       <= 1'b0;
      trig_mask     <= '0;
      trig_val      <= '0;
      tc            <= '0;
      wp            <= '0;
      valid         <= '0;
      long_mode     <= 1'b0;
      lb_cnt        <= '0;
      opcode        <= '0;
      lval          <= '0;
      resp_on       <= 1'b0;
      resp_meta     <= 1'b0;
      resp_idx      <= '0;
      armLEDnn      <= 1'b1;
      triggerLEDnn  <= 1'b1;
      extTriggerOut <= 1'b0;
      extClockOut   <= 1'b0;
    end else begin
      tg_s1         <= extTriggerIn;
      tg_s2         <= tg_s1;
      extTriggerOut <= 1'b0;
      div_cnt       <= strobe ? '0 : div_cnt + 1'b1;
      if (strobe) begin
        tc          <= tc + 1'b1;
        extClockOut <= ~extClockOut;
      end
      if (mem_we) begin
        wp        <= wp + 1'b1;
        valid[wp] <= 1'b1;
      end

      if (rx_valid) begin
        if (long_mode) begin
          lval   <= {rx_data, lval[23:8]};
          lb_cnt <= lb_cnt + 1'b1;
          if (lb_cnt == 2'd3) long_mode <= 1'b0;
        end else if (rx_data[7]) begin
          long_mode <= 1'b1;
          opcode    <= rx_data;
          lb_cnt    <= '0;
        end
      end

      if (is_long_done && !busy_rd) begin
        case (opcode)
          8'h80: divider <= lv[23:0];
          8'h81: begin
            read_count  <= clamp(lv[15:0]);
            delay_count <= clamp(lv[31:16]);
          end
          8'h82: begin
            grp_dis   <= lv[5:2];
            test_mode <= lv[11];
          end
          8'hC0: trig_mask <= lv;
          8'hC1: trig_val  <= lv;
          8'hC2: trig_en   <= lv[27];
          default: ;
        endcase
      end

      if (resp_push) begin
        resp_idx <= resp_idx + 1'b1;
        if (resp_last) resp_on <= 1'b0;
      end
      if (is_short && !busy_rd &&
          (rx_data == 8'h02 || rx_data == 8'h04)) begin
        resp_on   <= 1'b1;
        resp_meta <= rx_data[2];
        resp_idx  <= '0;
      end

      unique case (state)
        IDLE: ;
        ARMED: begin
          if (tg_s2 || (strobe && hit)) begin
            state         <= DELAY;
            extTriggerOut <= 1'b1;
            armLEDnn      <= 1'b1;
            triggerLEDnn  <= 1'b0;
            d_cnt         <= '0;
          end
        end
        DELAY: begin
          if (strobe) begin
            d_cnt <= d_cnt + 1'b1;
            if ((d_cnt + 1'b1) == delay_count) begin
              state <= READ;
              r_cnt <= '0;
              gi    <= '0;
            end
          end
        end
        READ: begin
          if (rd_step) begin
            gi <= gi + 1'b1;
            if (gi == 2'd3) begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == read_count - 1'b1) begin
                state        <= IDLE;
                triggerLEDnn <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (is_arm) begin
        state        <= ARMED;
        armLEDnn     <= 1'b0;
        triggerLEDnn <= 1'b1;
        wp           <= '0;
        valid        <= '0;
        div_cnt      <= '0;
      end
      if (flush) begin
        state        <= IDLE;
        armLEDnn     <= 1'b1;
        triggerLEDnn <= 1'b1;
        resp_on      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_de1_logic_sniffer.sv
// tb_de1_logic_sniffer: scoreboard bench for the SUMP sniffer.
// Host bytes go out on uart_rx; a UART monitor decodes uart_tx.
module tb_de1_logic_sniffer;
  localparam int FREQ = 16_000_000;
  localparam int BAUD = 1_000_000;
  localparam int BIT  = FREQ / BAUD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        extClockIn = 1'b0;
  logic        extTriggerIn = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] extData = '0;
  logic        extClockOut, extTriggerOut, dataReady;
  logic        armLEDnn, triggerLEDnn, uart_tx;

  int checks = 0;
  int passed = 0;
  logic [7:0] rxq [$];
  logic [7:0] expq [$];
  bit dr_drop;

  de1_logic_sniffer #(
    .FREQ(FREQ), .BAUD(BAUD), .DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .extClockIn(extClockIn),
    .extClockOut(extClockOut),
    .extTriggerIn(extTriggerIn),
    .extTriggerOut(extTriggerOut),
    .extData(extData),
    .dataReady(dataReady),
    .armLEDnn(armLEDnn),
    .triggerLEDnn(triggerLEDnn),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;

  initial begin : monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst && uart_tx === 1'b0) begin
        repeat (BIT / 2) @(negedge clk);
        if (dataReady !== 1'b1) dr_drop = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = uart_tx;
          if (dataReady !== 1'b1) dr_drop = 1'b1;
        end
        repeat (BIT) @(negedge clk);
        if (uart_tx === 1'b1) rxq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic send_long(input logic [7:0] op, input logic [31:0] v);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int t;
    t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    ok = (rxq.size() >= n);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) $display("FAIL rst_uart_tx got %b want 1", uart_tx); else passed++;
    checks++; if (dataReady !== 1'b0) $display("FAIL rst_dataReady got %b want 0", dataReady); else passed++;
    checks++; if (armLEDnn !== 1'b1) $display("FAIL rst_armLED got %b want 1", armLEDnn); else passed++;
    checks++; if (triggerLEDnn !== 1'b1) $display("FAIL rst_trigLED got %b want 1", triggerLEDnn); else passed++;
    checks++; if (extTriggerOut !== 1'b0) $display("FAIL rst_trigOut got %b want 0", extTriggerOut); else passed++;
    checks++; if (extClockOut !== 1'b0) $display("FAIL rst_clkOut got %b want 0", extClockOut); else passed++;
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_id;
    bit ok;
    logic [7:0] got, exp_b;
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    send_byte(8'h7F);
    expq = '{8'h31, 8'h41, 8'h4C, 8'h53};
    dr_drop = 1'b0;
    send_byte(8'h02);
    wait_rx(4, 2000, ok);
    checks++; if (!ok) $display("FAIL id_timeout got %0d bytes want 4", rxq.size()); else passed++;
    checks++; if (dataReady !== 1'b1) $display("FAIL id_dr_stop got %b want 1", dataReady); else passed++;
    while (expq.size() > 0) begin
      exp_b = expq.pop_front();
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      checks++; if (got !== exp_b) $display("FAIL id_byte got %02h want %02h", got, exp_b); else passed++;
    end
    checks++; if (dr_drop) $display("FAIL id_dr_gap got 0 want 1"); else passed++;
    repeat (BIT) @(negedge clk);
    checks++; if (dataReady !== 1'b0) $display("FAIL id_dr_fall got %b want 0", dataReady); else passed++;
  endtask

  task automatic test_meta;
    bit ok;
    logic [7:0] got, exp_b;
    expq = '{8'h01, 8'h44, 8'h45, 8'h31, 8'h00, 8'h00};
    send_byte(8'h04);
    wait_rx(6, 3000, ok);
    checks++; if (!ok) $display("FAIL meta_timeout got %0d bytes want 6", rxq.size()); else passed++;
    while (expq.size() > 0) begin
      exp_b = expq.pop_front();
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      checks++; if (got !== exp_b) $display("FAIL meta_byte got %02h want %02h", got, exp_b); else passed++;
    end
    repeat (4 * BIT) @(negedge clk);
  endtask

  task automatic test_capture(input logic [31:0] flags, input int nb);
    bit ok;
    logic [7:0] got, exp_b, c;
    send_long(8'hC0, 32'h0000_00FF);
    send_long(8'hC1, 32'h0000_0040);
    send_long(8'hC2, 32'h0800_0000);
    send_long(8'h82, flags);
    send_long(8'h80, 32'h0);
    send_long(8'h81, 32'h0004_0004);
    for (int s = 0; s < 20; s++) begin
      c = 8'h54 - 8'(s);
      expq.push_back(c);
      if (!flags[3]) expq.push_back({2'b01, c[5:0]});
    end
    send_byte(8'h01);
    wait_rx(nb, 12000, ok);
    checks++; if (!ok) $display("FAIL cap_timeout got %0d bytes want %0d", rxq.size(), nb); else passed++;
    while (expq.size() > 0) begin
      exp_b = expq.pop_front();
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      checks++; if (got !== exp_b) $display("FAIL cap_byte got %02h want %02h", got, exp_b); else passed++;
    end
    repeat (30 * BIT) @(negedge clk);
    checks++; if (rxq.size() != 0) $display("FAIL cap_extra got %0d bytes want 0", rxq.size()); else passed++;
    rxq.delete();
  endtask

  task automatic test_unwritten;
    bit ok;
    logic [7:0] got, exp_b;
    extData = 32'h0000_00A5;
    send_long(8'hC2, 32'h0);
    send_long(8'h82, 32'h0000_0038);
    send_long(8'h81, 32'h0000_0001);
    expq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_byte(8'h01);
    wait_rx(8, 4000, ok);
    checks++; if (!ok) $display("FAIL unw_timeout got %0d bytes want 8", rxq.size()); else passed++;
    while (expq.size() > 0) begin
      exp_b = expq.pop_front();
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      checks++; if (got !== exp_b) $display("FAIL unw_byte got %02h want %02h", got, exp_b); else passed++;
    end
    repeat (30 * BIT) @(negedge clk);
    checks++; if (rxq.size() != 0) $display("FAIL unw_extra got %0d bytes want 0", rxq.size()); else passed++;
    rxq.delete();
  endtask

  task automatic test_ext_trigger;
    int pulses, t;
    send_long(8'h80, 32'd500);
    send_long(8'h81, 32'h0);
    send_long(8'h82, 32'h0000_083C);
    send_byte(8'h01);
    repeat (20) @(negedge clk);
    checks++; if (armLEDnn !== 1'b0) $display("FAIL ext_armLED got %b want 0", armLEDnn); else passed++;
    checks++; if (triggerLEDnn !== 1'b1) $display("FAIL ext_trigLED_pre got %b want 1", triggerLEDnn); else passed++;
    extTriggerIn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 10) extTriggerIn = 1'b0;
      if (extTriggerOut === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) $display("FAIL ext_pulses got %0d want 1", pulses); else passed++;
    checks++; if (triggerLEDnn !== 1'b0) $display("FAIL ext_trigLED got %b want 0", triggerLEDnn); else passed++;
    checks++; if (armLEDnn !== 1'b1) $display("FAIL ext_armLED_post got %b want 1", armLEDnn); else passed++;
    repeat (1000) @(negedge clk);
    checks++; if (triggerLEDnn !== 1'b0) $display("FAIL ext_trigLED_hold got %b want 0", triggerLEDnn); else passed++;
    t = 0;
    while (triggerLEDnn !== 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++; if (triggerLEDnn !== 1'b1) $display("FAIL ext_readout_end got %b want 1", triggerLEDnn); else passed++;
    repeat (4 * BIT) @(negedge clk);
    checks++; if (rxq.size() != 0) $display("FAIL ext_no_groups got %0d bytes want 0", rxq.size()); else passed++;
    checks++; if (dataReady !== 1'b0) $display("FAIL ext_dataReady got %b want 0", dataReady); else passed++;
  endtask

  task automatic test_reset_mid_readout;
    bit ok;
    logic [7:0] got, exp_b;
    send_long(8'h80, 32'h0);
    send_long(8'h81, 32'h0004_0004);
    send_long(8'h82, 32'h0000_0830);
    send_long(8'hC0, 32'h0000_00FF);
    send_long(8'hC1, 32'h0000_0040);
    send_long(8'hC2, 32'h0800_0000);
    send_byte(8'h01);
    wait_rx(3, 6000, ok);
    checks++; if (!ok) $display("FAIL mid_timeout got %0d bytes want 3", rxq.size()); else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) $display("FAIL mid_uart_tx got %b want 1", uart_tx); else passed++;
    checks++; if (dataReady !== 1'b0) $display("FAIL mid_dataReady got %b want 0", dataReady); else passed++;
    checks++; if (triggerLEDnn !== 1'b1) $display("FAIL mid_trigLED got %b want 1", triggerLEDnn); else passed++;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    rxq.delete();
    repeat (400) @(negedge clk);
    checks++; if (rxq.size() != 0) $display("FAIL mid_idle_bytes got %0d want 0", rxq.size()); else passed++;
    checks++; if (dataReady !== 1'b0) $display("FAIL mid_idle_dr got %b want 0", dataReady); else passed++;
    expq = '{8'h31, 8'h41, 8'h4C, 8'h53};
    send_byte(8'h02);
    wait_rx(4, 2000, ok);
    checks++; if (!ok) $display("FAIL mid_id_timeout got %0d bytes want 4", rxq.size()); else passed++;
    while (expq.size() > 0) begin
      exp_b = expq.pop_front();
      got = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
      checks++; if (got !== exp_b) $display("FAIL mid_id_byte got %02h want %02h", got, exp_b); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_id();
    test_meta();
    test_capture(32'h0000_0838, 20);
    test_capture(32'h0000_0830, 40);
    test_unwritten();
    test_ext_trigger();
    test_reset_mid_readout();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/de1_logic_sniffer.md
Name: de1_logic_sniffer

Overview:
- SUMP-compatible 32-channel logic analyzer top for the Terasic DE1 board.
- Host sends commands over a UART link (8N1); the block captures extData (or an internal test pattern) into on-chip memory around a trigger event.
- Captured samples are streamed back over the UART; dataReady tells an external controller that response bytes are pending.

Parameters:
- FREQ, 50_000_000: clk frequency in Hz.
- BAUD, 921_600: UART bit rate; bit period = FREQ/BAUD clocks, truncated (54 at defaults).
- DEPTH, 64: sample memory depth in 32-bit words (power of 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- extClockIn  in  1  external sample clock; unused, ignored.
- extClockOut  out  1  toggles on every sample strobe.
- extTriggerIn  in  1  external trigger; sampled through a 2-FF synchronizer.
- extTriggerOut  out  1  one-cycle pulse when the trigger fires.
- extData  in  32  sampled logic inputs.
- dataReady  out  1  high while response bytes are queued or being transmitted.
- armLEDnn  out  1  low while armed and waiting for trigger.
- triggerLEDnn  out  1  low from trigger until the end of readout.
- uart_tx  out  1  UART to host; idles high.
- uart_rx  in  1  UART from host; passed through a 2-FF synchronizer.

Behaviour:
- Reset values:
  - Ports: uart_tx=1, dataReady=0, armLEDnn=1, triggerLEDnn=1, extTriggerOut=0, extClockOut=0.
  - Registers: all cleared; state IDLE.
- UART RX:
  - Start bit is detected on a falling edge and confirmed at mid-bit.
  - Data bits are sampled at mid-bit, LSB first.
  - A frame whose stop bit is 0 is discarded.
- UART TX:
  - Format: 8N1, LSB first.
  - Fed from an 8-deep byte FIFO; output is back-to-back with no inter-frame gap.
- Command parser:
  - Byte with bit7 = 0 is a short command.
  - Byte with bit7 = 1 is followed by 4 value bytes, little-endian; the command executes after the 4th byte.
- Short commands:
  - 0x00: reset. Abort capture, flush TX, state IDLE; configuration registers are kept.
  - 0x01: arm. Go to ARMED.
  - 0x02: ID. Queue 0x31 0x41 0x4C 0x53 ("1ALS").
  - 0x04: metadata. Queue 0x01 'D' 'E' '1' 0x00 0x00.
  - All other short codes are ignored (e.g. 0x7F).
- Long commands:
  - 0x80 divider[23:0]: sample strobe every divider+1 clocks.
  - 0x81 read/delay: readCount = (v[15:0]+1)*4 samples; delayCount = (v[31:16]+1)*4 samples.
  - Both counts are clamped to DEPTH.
  - 0x82 flags:
    - bits[5:2] disable channel groups 0..3 (group g = extData[8g+7:8g]).
    - bit11 selects internal test mode.
  - 0xC0 trigger mask, 0xC1 trigger value, 0xC2 trigger config (bit27 = trigger enable).
  - Other long codes are ignored.
- Sample source:
  - Test mode uses an 8-bit counter c that increments per sample strobe.
  - Group0 byte = c.
  - Group g (1..3) byte = {g[1:0], c[5:0]}.
  - Otherwise the source is extData.
- Capture state machine:
  - IDLE -> ARMED on 0x01.
  - ARMED: write a sample into a circular RAM on every strobe.
  - Trigger fires when extTriggerIn is high, or when config bit27 = 1 and (sample & mask) == (value & mask).
  - If bit27 = 0, the trigger fires on the first sample.
  - On trigger: pulse extTriggerOut and go to DELAY.
  - DELAY: capture delayCount further samples, then READ.
  - READ: send readCount samples, newest first.
  - For each sample, queue the bytes of enabled groups in ascending group order (0 to 4 bytes per sample).
  - READ -> IDLE after the last byte has been queued.
- dataReady:
  - High from the first queued response byte until the TX FIFO is empty and the last stop bit has completed.
  - Commands received during READ are ignored except 0x00.
- Boundary conditions:
  - If all groups are disabled, READ sends nothing.
  - If the RAM has not yet wrapped, unwritten words read as 0.
  - The parser accepts RX bytes in every state.

Test Plan:
- Send 0x00 five times, then 0x02 -> uart_tx emits 0x31,0x41,0x4C,0x53; dataReady=1 throughout, then falls to 0.
- Send 0x04 -> uart_tx emits 0x01,0x44,0x45,0x31,0x00,0x00.
- Configure mask=0xFF, value=0x40, config=0x08000000, flags=0x838 (test mode, only group0 enabled), divider=0, read/delay=0x00040004, then 0x01 -> trigger fires when c=0x40; 20 bytes return, newest first, 0x54 down to 0x41.
- Same setup with flags=0x830 (groups 0 and 1 enabled) -> 40 bytes; each sample sends c, then {2'b01, c[5:0]}.
- Send 0x01, then assert extTriggerIn while mask=0 -> extTriggerOut pulses once; triggerLEDnn=0 until readout ends.
- Pull rst low mid-readout -> uart_tx=1, dataReady=0, state IDLE immediately.
